seg_disp_sched: RTL and testbench

Display scheduler that shares the single 4-digit seven-segment display between several requesters (score counter, game timer, status message) and drives the multiplexed digit scan. Each requester presents a 4-digit BCD value and a request; the block grants one requester at a time with a minimum ownership window, round-robin between contenders, and scans the granted value onto `select`/`seg`. It sits between the game logic and the board display pins, replacing direct per-source display wiring.

---
 rtl/seg_disp_sched_pkg.sv | 38 +++
 rtl/seg_disp_sched_scan.sv | 56 +++++
 rtl/seg_disp_sched.sv | 90 +++++++++
 tb/tb_seg_disp_sched.sv | 112 +++++++++++
 4 files changed

// File: rtl/seg_disp_sched_pkg.sv
// seg_disp_sched_pkg: segment codes, digit select patterns and arbiter states shared by the display scheduler
package seg_disp_sched_pkg;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] SEL_D3  = 4'b0111;
  localparam logic [3:0] SEL_D2  = 4'b1011;
  localparam logic [3:0] SEL_D1  = 4'b1101;
  localparam logic [3:0] SEL_D0  = 4'b1110;
  localparam logic [3:0] SEL_OFF = 4'b1111;
  typedef enum logic {ST_IDLE, ST_OWN} state_t;
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
    case (n)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
  function automatic logic [3:0] sel_of(input logic [1:0] idx);
    return (idx == 2'd0) ? SEL_D3 : (idx == 2'd1) ? SEL_D2 : (idx == 2'd2) ? SEL_D1 : SEL_D0;
  endfunction
endpackage

// File: rtl/seg_disp_sched_scan.sv
// seg_scan: prescaler, digit index, nibble mux and registered BCD-to-segment output for a 4-digit display.
// SEG_BLANK_LEAD_ZERO_EN blanks leading zero digits (digit 0 always shown).
module seg_scan
  import seg_disp_sched_pkg::*;
#(
  parameter int SCAN_DIV = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_active,
  input  logic [15:0] i_value,
  output logic [3:0]  o_select,
  output logic [6:0]  o_seg
);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic [3:0]    r_select;
  logic [6:0]    r_seg;
  logic          w_tick;
  logic [1:0]    w_idx;
  logic [1:0]    w_n;
  logic [3:0]    w_nib;
  logic          w_lead;
  logic [6:0]    w_seg;
  assign w_tick = r_pre == PW'(SCAN_DIV - 1);
  assign w_idx  = r_idx + 2'd1;
  // index 0 shows the leftmost nibble, so the nibble number is the inverted index
  assign w_n    = ~w_idx;
  assign w_nib  = i_value[{w_n, 2'b00} +: 4];
`ifdef SEG_BLANK_LEAD_ZERO_EN
  assign w_lead = (w_n == 2'd3) ? (i_value[15:12] == 4'd0) :
                  (w_n == 2'd2) ? (i_value[15:8] == 8'd0) :
                  (w_n == 2'd1) ? (i_value[15:4] == 12'd0) : 1'b0;
`else
  assign w_lead = 1'b0;
`endif
  assign w_seg = (!i_active || w_lead) ? SEG_BLANK : bcd_to_seg(w_nib);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre    <= '0;
      r_idx    <= '0;
      r_select <= SEL_OFF;
      r_seg    <= SEG_BLANK;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        r_idx    <= w_idx;
        r_select <= sel_of(w_idx);
        r_seg    <= w_seg;
      end
    end
  end
  assign o_select = r_select;
  assign o_seg    = r_seg;
endmodule

// File: rtl/seg_disp_sched.sv
// seg_disp_sched: round-robin display arbiter with minimum hold window driving a shared multiplexed 7-seg display.
// SEG_BLANK_LEAD_ZERO_EN (in seg_scan) enables leading-zero blanking.
module seg_disp_sched
  import seg_disp_sched_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int HOLD_CYCLES = 1024,
  parameter int SCAN_DIV    = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [16*NREQ-1:0]  data,
  output logic [NREQ-1:0]     grant,
  output logic [3:0]          select,
  output logic [6:0]          seg
);
  localparam int IW = $clog2(NREQ);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
  state_t        r_state;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_ptr;
  logic [HW-1:0] r_hold;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] w_others;
  logic [IW-1:0]   w_ptr_next;
  logic [IW-1:0]   w_pick_idle;
  logic [IW-1:0]   w_pick_next;
  logic [15:0]     w_value;
  // first set bit of r at or after start, in cyclic order
  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r, input logic [IW-1:0] start);
    logic [IW-1:0] res;
    logic          found;
    int            j;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(start) + k) % NREQ;
      if (!found && r[j]) begin
        res   = IW'(j);
        found = 1'b1;
      end
    end
    return res;
  endfunction
  assign w_others    = req & ~r_grant;
  assign w_ptr_next  = (int'(r_owner) == NREQ - 1) ? '0 : r_owner + 1'b1;
  assign w_pick_idle = pick(req, r_ptr);
  assign w_pick_next = pick(w_others, w_ptr_next);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_grant <= '0;
    end else if (r_state == ST_IDLE) begin
      if (|req) begin
        r_state <= ST_OWN;
        r_owner <= w_pick_idle;
        r_grant <= NREQ'(1) << w_pick_idle;
        r_hold  <= HOLD_INIT;
      end
    end else if (!req[r_owner] || (r_hold == '0 && |w_others)) begin
      r_ptr <= w_ptr_next;
      if (|w_others) begin
        r_owner <= w_pick_next;
        r_grant <= NREQ'(1) << w_pick_next;
        r_hold  <= HOLD_INIT;
      end else begin
        r_state <= ST_IDLE;
        r_grant <= '0;
        r_hold  <= '0;
      end
    end else if (r_hold != '0) begin
      r_hold <= r_hold - 1'b1;
    end
  end
  assign w_value = data[{r_owner, 4'b0000} +: 16];
  assign grant   = r_grant;
  seg_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk      (clk),
    .rst      (rst),
    .i_active (r_state == ST_OWN),
    .i_value  (w_value),
    .o_select (select),
    .o_seg    (seg)
  );
endmodule

// File: tb/tb_seg_disp_sched.sv
// tb_seg_disp_sched: directed checks of arbitration, hold window, hand-off, scan and async reset.
module tb_seg_disp_sched;
  localparam int SD = 16;
  localparam logic [6:0] SEGT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [3:0] EXP_SEL [4] = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [47:0] data = '0;
  logic [2:0]  grant;
  logic [3:0]  select;
  logic [6:0]  seg;
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int g = 0;
  seg_disp_sched #(.NREQ(3), .HOLD_CYCLES(1024), .SCAN_DIV(SD)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .data   (data),
    .grant  (grant),
    .select (select),
    .seg    (seg)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] model(input logic [3:0] sel, input logic [15:0] v);
    int n;
    logic [3:0] d;
    logic blank;
    n = (sel == 4'b0111) ? 3 : (sel == 4'b1011) ? 2 : (sel == 4'b1101) ? 1 : 0;
    d = 4'(v >> (4 * n));
    blank = 1'b0;
`ifdef SEG_BLANK_LEAD_ZERO_EN
    blank = (n > 0) && ((v >> (4 * n)) == 16'd0);
`endif
    return blank ? 7'h7F : SEGT[d];
  endfunction
  task automatic wait_tick();
    logic [3:0] p;
    bit seen;
    p = select;
    seen = 1'b0;
    for (int i = 0; i < SD + 2 && !seen; i++) begin
      @(negedge clk);
      seen = select !== p;
    end
    if (!seen) check("tick_timeout", 32'd0, 32'd1);
  endtask
  task automatic scan4(input string tag, input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      check(tag, seg, model(select, v));
    end
  endtask
  initial begin
    bit done;
    #12;
    check("rst_grant", grant, 3'b000);
    check("rst_select", select, 4'b1111);
    check("rst_seg", seg, 7'h7F);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      check("idle_select", select, EXP_SEL[i]);
      check("idle_seg", seg, 7'h7F);
    end
    @(negedge clk);
    data[15:0] = 16'h1234;
    req = 3'b001;
    @(negedge clk) check("grant0", grant, 3'b001);
    scan4("scan_1234", 16'h1234);
    req = 3'b000;
    @(negedge clk) check("release", grant, 3'b000);
    req = 3'b001;
    @(negedge clk) check("regrant0", grant, 3'b001);
    g = cyc;
    repeat (10) @(negedge clk);
    req = 3'b011;
    done = 1'b0;
    for (int i = 0; i < 1100 && !done; i++) begin
      @(negedge clk);
      done = grant !== 3'b001;
    end
    check("hold_grant", grant, 3'b010);
    check("hold_cycles", cyc - g, 1024);
    data[47:32] = 16'h0070;
    req = 3'b101;
    @(negedge clk) check("handoff", grant, 3'b100);
    scan4("scan_0070", 16'h0070);
    #2 rst = 1'b0;
    #1;
    check("async_grant", grant, 3'b000);
    check("async_select", select, 4'b1111);
    check("async_seg", seg, 7'h7F);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) check("rearb0", grant, 3'b001);
    data[15:0] = 16'h8A5F;
    scan4("scan_8a5f", 16'h8A5F);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
